// File: rtl/pc_pkg.sv
// Shared constants and types for the program counter.
// Default address width, reset vector and sequential step live here so that
// the top and the incrementer agree on them.
package pc_pkg;

    localparam int PC_ADDR_W = 16;
    localparam logic [PC_ADDR_W-1:0] PC_RESET_ADDR = 16'h0000;
    // Instructions are 16-bit words in byte-addressed memory.
    localparam int PC_INC_STEP = 2;

    typedef logic [PC_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational PC + step adder. The sum is truncated to the address width,
// so the top of memory wraps back to address zero.
module pc_incrementer
    import pc_pkg::*;
#(
    parameter int ADDR_W   = PC_ADDR_W,
    parameter int INC_STEP = PC_INC_STEP
) (
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] sum_o
);

    // Wrapping add; carry out of the top bit is discarded.
    always_comb begin
        sum_o = pc_i + ADDR_W'(INC_STEP);
    end

endmodule

// File: rtl/program_counter.sv
// Program counter: holds the current instruction address.
// Update priority per rising edge: reset, then load (pcWrite), then
// increment (pcInc), otherwise hold. outputAddress comes straight from the
// register, so there is no combinational path from inputAddress.
// Optional feature macro: PC_ALIGN_CHECK_EN adds a registered misalignFault
// output flagging a load of an address that is not a multiple of INC_STEP.
module program_counter
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = PC_RESET_ADDR,
    parameter int                INC_STEP   = PC_INC_STEP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pcWrite,
    input  logic              pcInc,
    input  logic [ADDR_W-1:0] inputAddress,
`ifdef PC_ALIGN_CHECK_EN
    output logic              misalignFault,
`endif
    output logic [ADDR_W-1:0] outputAddress,
    output logic [ADDR_W-1:0] nextSeqAddress
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus_step;

    // One adder serves both the increment path and nextSeqAddress.
    pc_incrementer #(
        .ADDR_W   (ADDR_W),
        .INC_STEP (INC_STEP)
    ) u_incrementer (
        .pc_i  (pc_q),
        .sum_o (pc_plus_step)
    );

    // Next PC: load beats increment; reset is handled in the register so an
    // unknown pcWrite/pcInc during reset cannot reach pc_q.
    always_comb begin
        pc_d = pc_q;
        if (pcWrite) begin
            pc_d = inputAddress;
        end else if (pcInc) begin
            pc_d = pc_plus_step;
        end
    end

    // PC register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign outputAddress  = pc_q;
    assign nextSeqAddress = pc_plus_step;

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q;
    logic fault_d;

    // Fault follows the most recent PC update: a load sets it from the
    // target's alignment, an increment clears it, a hold keeps it.
    always_comb begin
        fault_d = fault_q;
        if (pcWrite) begin
            fault_d = ((inputAddress % ADDR_W'(INC_STEP)) != '0);
        end else if (pcInc) begin
            fault_d = 1'b0;
        end
    end

    // Fault register, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign misalignFault = fault_q;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Testbench for program_counter: directed sequence from the test plan plus
// randomized cycles, checked against an arithmetic reference model.
module tb_program_counter;

    logic        clock;
    logic        reset;
    logic        pcWrite;
    logic        pcInc;
    logic [15:0] inputAddress;
    logic [15:0] outputAddress;
    logic [15:0] nextSeqAddress;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalignFault;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: the architectural PC as a plain integer.
    int unsigned model_pc    = 0;
    bit          model_fault = 0;

    program_counter dut (
        .clock          (clock),
        .reset          (reset),
        .pcWrite        (pcWrite),
        .pcInc          (pcInc),
        .inputAddress   (inputAddress),
`ifdef PC_ALIGN_CHECK_EN
        .misalignFault  (misalignFault),
`endif
        .outputAddress  (outputAddress),
        .nextSeqAddress (nextSeqAddress)
    );

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then
    // compare all outputs 1 time unit after the edge.
    task automatic step(input string tag, input logic r, input logic w,
                        input logic i, input logic [15:0] a);
        reset        = r;
        pcWrite      = w;
        pcInc        = i;
        inputAddress = a;
        @(posedge clock);
        if (r === 1'b1) begin
            model_pc    = 0;
            model_fault = 0;
        end else if (w === 1'b1) begin
            model_pc    = a;
            model_fault = (a % 2) != 0;
        end else if (i === 1'b1) begin
            model_pc    = (model_pc + 2) % 65536;
            model_fault = 0;
        end
        #1;
        check_eq({tag, ".pc"}, outputAddress, 16'(model_pc));
        check_eq({tag, ".next"}, nextSeqAddress, 16'((model_pc + 2) % 65536));
`ifdef PC_ALIGN_CHECK_EN
        check_eq({tag, ".fault"}, {15'd0, misalignFault}, {15'd0, model_fault});
`endif
    endtask

    initial begin
        reset        = 1'b1;
        pcWrite      = 1'b0;
        pcInc        = 1'b0;
        inputAddress = 16'h0000;
        #2;

        // Test plan sequence.
        step("reset",      1'b1, 1'b0, 1'b0, 16'h0000);
        step("load_aaaa",  1'b0, 1'b1, 1'b0, 16'hAAAA);
        step("hold",       1'b0, 1'b0, 1'b0, 16'hBBBB);
        step("load_cccc",  1'b0, 1'b1, 1'b0, 16'hCCCC);
        step("rst_vs_ld",  1'b1, 1'b1, 1'b1, 16'hDDDD);
        step("load_fffc",  1'b0, 1'b1, 1'b0, 16'hFFFC);
        step("inc_fffe",   1'b0, 1'b0, 1'b1, 16'h5555);
        step("inc_wrap",   1'b0, 1'b0, 1'b1, 16'h5555);
        step("inc_0002",   1'b0, 1'b0, 1'b1, 16'h5555);
        step("ld_vs_inc",  1'b0, 1'b1, 1'b1, 16'h1234);
        step("load_odd",   1'b0, 1'b1, 1'b0, 16'h0003);
        step("hold_odd",   1'b0, 1'b0, 1'b0, 16'h0000);
        step("inc_odd",    1'b0, 1'b0, 1'b1, 16'h0000);
        step("load_odd2",  1'b0, 1'b1, 1'b0, 16'h7FFF);
        step("load_even",  1'b0, 1'b1, 1'b0, 16'h0010);

        // Unknown enables during reset must not disturb the reset value.
        step("rst_x",      1'b1, 1'bx, 1'bx, 16'h9999);

        // A reset pulse between edges, and inputAddress changes between
        // edges, must not be visible on outputAddress.
        step("load_4242",  1'b0, 1'b1, 1'b0, 16'h4242);
        #2;
        reset        = 1'b1;
        inputAddress = 16'hEEEE;
        pcWrite      = 1'b1;
        #1;
        check_eq("midcycle_rst.pc", outputAddress, 16'(model_pc));
        reset   = 1'b0;
        pcWrite = 1'b0;
        step("after_glitch", 1'b0, 1'b0, 1'b0, 16'hEEEE);

        // Randomized traffic; rare resets, frequent loads near the wrap point.
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        w;
            logic        i;
            logic [15:0] a;
            r = ($urandom_range(0, 19) == 0);
            w = ($urandom_range(0, 3) == 0);
            i = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                a = 16'hFFF0 | 16'($urandom_range(0, 15));
            end else begin
                a = 16'($urandom);
            end
            step("rand", r, w, i, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Holds the processor's current instruction address.
- Updates on the rising clock edge, either by a direct load (jump/branch target from the datapath) or by a sequential increment.
- Feeds the instruction-memory address bus and the PC+step adder path of the CPU datapath.

Parameters:
- ADDR_W, 16, width of the address in bits.
- RESET_ADDR, 16'h0000, value loaded into the PC on reset.
- INC_STEP, 2, amount added on an increment. Instructions are 16-bit words in byte-addressed memory.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pcWrite  input  1  load enable; when 1, the PC takes inputAddress at the next edge.
- pcInc  input  1  increment enable; when 1 and pcWrite=0, the PC advances by INC_STEP at the next edge.
- inputAddress  input  ADDR_W  load value (jump/branch target).
- outputAddress  output  ADDR_W  current PC, registered, driven directly from the PC register.
- nextSeqAddress  output  ADDR_W  combinational outputAddress + INC_STEP, modulo 2^ADDR_W.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Single ADDR_W-bit register pc; outputAddress = pc at all times.
- Update priority at each rising edge of clock:
  1. reset=1 -> pc <= RESET_ADDR.
  2. else pcWrite=1 -> pc <= inputAddress.
  3. else pcInc=1 -> pc <= pc + INC_STEP.
  4. else hold.
- Latency: a load or increment is visible on outputAddress one clock after the enabling edge. There is no combinational path from inputAddress to outputAddress.
- Reset is sampled only at the clock edge. Asserting reset between edges has no effect until the next rising edge.
- Reset asserted together with pcWrite and/or pcInc: reset wins.
- pcWrite and pcInc both high: the load wins and the increment is ignored.
- Increment wrap-around: the sum is truncated to ADDR_W bits. With INC_STEP=2, 16'hFFFE -> 16'h0000.
- nextSeqAddress wraps identically.
- X on pcWrite or pcInc while reset=1 must not corrupt pc.
- Before the first reset, pc is undefined. Benches must apply reset first.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined, adds output misalignFault (1 bit, registered). It is set at the same edge pc loads an inputAddress whose low bit is 1 (inputAddress % INC_STEP != 0), and cleared by reset or by any subsequent valid load or increment.
- The PC still loads the misaligned value; the fault only flags it.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pc_pkg:
  - ADDR_W default constant.
  - RESET_ADDR constant.
  - INC_STEP constant.
  - typedef addr_t (logic [ADDR_W-1:0]).
- One natural sub-module, pc_incrementer: a combinational adder producing pc + INC_STEP with wrap. It drives both the increment path and nextSeqAddress.

Test Plan:
- Reset: reset=1 for one edge, pcWrite=0 -> outputAddress=16'h0000 after the edge.
- Load then hold:
  - reset=0, pcWrite=1, inputAddress=16'hAAAA -> 16'hAAAA after the next edge.
  - Then pcWrite=0, pcInc=0, inputAddress=16'hBBBB -> stays 16'hAAAA.
- Reload, then reset priority:
  - pcWrite=1, inputAddress=16'hCCCC -> 16'hCCCC.
  - Then reset=1, pcWrite=1, inputAddress=16'hDDDD -> 16'h0000, not DDDD.
- Increment and wrap:
  - Load 16'hFFFC, then pcInc=1 for two edges -> 16'hFFFE, then 16'h0000.
  - nextSeqAddress equals outputAddress+2 each cycle.
- Load beats increment: pcWrite=1, pcInc=1, inputAddress=16'h1234 -> 16'h1234, not current+2.
- PC_ALIGN_CHECK_EN:
  - Load 16'h0003 -> misalignFault=1 with PC=16'h0003.
  - Next pcInc edge -> misalignFault=0.
